// File: rtl/dffram_rr_arbiter.sv
// dffram_rr_arbiter: two-port round-robin arbiter/sequencer in front of a
// single-port (1RW) DFFRAM macro with byte write enables.
// Optional feature macro: DFFRAM_ARB_LOCK_EN (adds p0_lock/p1_lock, lets an
// accepted port own the RAM until it issues an unlocked beat).
// Read data returns RD_LAT cycles after the command edge, steered by a tag
// pipeline that remembers which port issued each in-flight read.
module dffram_rr_arbiter #(
    parameter int AW     = 5,
    parameter int WSIZE  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    // port 0
    input  logic                 p0_valid,
    output logic                 p0_ready,
    input  logic [WSIZE-1:0]     p0_we,
    input  logic [AW-1:0]        p0_addr,
    input  logic [8*WSIZE-1:0]   p0_di,
    output logic                 p0_rvalid,
    output logic [8*WSIZE-1:0]   p0_rdata,
    // port 1
    input  logic                 p1_valid,
    output logic                 p1_ready,
    input  logic [WSIZE-1:0]     p1_we,
    input  logic [AW-1:0]        p1_addr,
    input  logic [8*WSIZE-1:0]   p1_di,
    output logic                 p1_rvalid,
    output logic [8*WSIZE-1:0]   p1_rdata,
`ifdef DFFRAM_ARB_LOCK_EN
    // bus lock requests, sampled with each accepted beat
    input  logic                 p0_lock,
    input  logic                 p1_lock,
`endif
    // RAM macro command/data
    output logic                 ram_en,
    output logic [WSIZE-1:0]     ram_we,
    output logic [AW-1:0]        ram_a,
    output logic [8*WSIZE-1:0]   ram_di,
    input  logic [8*WSIZE-1:0]   ram_do
);

    localparam int DW = 8 * WSIZE;
    // Tag stage 0 is written at the command edge; stage RD_LAT lines up with
    // the cycle in which ram_do carries that command's data.
    localparam int TD = RD_LAT + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 r_last_grant;   // 1 = port 1 was granted last
    logic                 r_ram_en;
    logic [WSIZE-1:0]     r_ram_we;
    logic [AW-1:0]        r_ram_a;
    logic [DW-1:0]        r_ram_di;
    logic                 r_tag_vld  [TD];
    logic                 r_tag_port [TD];

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic                 w_rr0;
    logic                 w_rr1;
    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_accept;
    logic                 w_port;
    logic [WSIZE-1:0]     w_sel_we;
    logic [AW-1:0]        w_sel_addr;
    logic [DW-1:0]        w_sel_di;
    logic                 w_is_read;
    logic                 w_out_vld;
    logic                 w_out_port;

`ifdef DFFRAM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        LK_FREE = 2'd0,
        LK_OWN0 = 2'd1,
        LK_OWN1 = 2'd2
    } lk_state_t;

    lk_state_t            r_lk_state;
    lk_state_t            w_lk_next;
    logic                 w_sel_lock;
`endif

    // Plain round-robin choice: a lone requester wins, a tie goes to the
    // port that was not granted last.
    always_comb begin
        w_rr0 = p0_valid && (!p1_valid || r_last_grant);
        w_rr1 = p1_valid && (!p0_valid || !r_last_grant);
    end

    // Final grant; nothing is granted while reset is held, and under a lock
    // only the owner may be granted (and only when it is requesting).
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!RST) begin
`ifdef DFFRAM_ARB_LOCK_EN
            case (r_lk_state)
                LK_OWN0: w_grant0 = p0_valid;
                LK_OWN1: w_grant1 = p1_valid;
                default: begin
                    w_grant0 = w_rr0;
                    w_grant1 = w_rr1;
                end
            endcase
`else
            w_grant0 = w_rr0;
            w_grant1 = w_rr1;
`endif
        end
    end

    // Select the winning request's payload.
    always_comb begin
        w_accept   = w_grant0 | w_grant1;
        w_port     = w_grant1;
        w_sel_we   = w_port ? p1_we   : p0_we;
        w_sel_addr = w_port ? p1_addr : p0_addr;
        w_sel_di   = w_port ? p1_di   : p0_di;
        w_is_read  = (w_sel_we == '0);
    end

    assign p0_ready = w_grant0;
    assign p1_ready = w_grant1;

    // Register the RAM command; address/data hold when idle, enables drop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ram_en     <= 1'b0;
            r_ram_we     <= '0;
            r_ram_a      <= '0;
            r_ram_di     <= '0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_ram_en     <= 1'b1;
            r_ram_we     <= w_sel_we;
            r_ram_a      <= w_sel_addr;
            r_ram_di     <= w_sel_di;
            r_last_grant <= w_port;
        end else begin
            r_ram_en     <= 1'b0;
            r_ram_we     <= '0;
        end
    end

    assign ram_en = r_ram_en;
    assign ram_we = r_ram_we;
    assign ram_a  = r_ram_a;
    assign ram_di = r_ram_di;

    // In-flight tag pipeline: stage 0 captures {read?, port} of the accepted
    // beat, later stages shift it along so it exits when ram_do is valid.
    // Reset empties it, so reads in flight at reset never produce rvalid.
    generate
        for (genvar gi = 0; gi < TD; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                // Capture the tag of the beat being accepted this edge.
                always_ff @(posedge CLK or posedge RST) begin
                    if (RST) begin
                        r_tag_vld[gi]  <= 1'b0;
                        r_tag_port[gi] <= 1'b0;
                    end else begin
                        r_tag_vld[gi]  <= w_accept & w_is_read;
                        r_tag_port[gi] <= w_port;
                    end
                end
            end else begin : g_shift
                // Advance the tag one stage per clock.
                always_ff @(posedge CLK or posedge RST) begin
                    if (RST) begin
                        r_tag_vld[gi]  <= 1'b0;
                        r_tag_port[gi] <= 1'b0;
                    end else begin
                        r_tag_vld[gi]  <= r_tag_vld[gi-1];
                        r_tag_port[gi] <= r_tag_port[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Steer ram_do to the port named by the exiting tag; data is zeroed
    // whenever that port has no response this cycle.
    always_comb begin
        w_out_vld  = r_tag_vld[RD_LAT];
        w_out_port = r_tag_port[RD_LAT];
        p0_rvalid  = w_out_vld & ~w_out_port;
        p1_rvalid  = w_out_vld &  w_out_port;
        p0_rdata   = p0_rvalid ? ram_do : '0;
        p1_rdata   = p1_rvalid ? ram_do : '0;
    end

`ifdef DFFRAM_ARB_LOCK_EN
    // Lock ownership register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_lk_state <= LK_FREE;
        end else begin
            r_lk_state <= w_lk_next;
        end
    end

    // Every accepted beat decides ownership: lock=1 makes the accepted port
    // the owner, lock=0 releases the arbiter. Idle cycles keep the state.
    always_comb begin
        w_lk_next  = r_lk_state;
        w_sel_lock = w_port ? p1_lock : p0_lock;
        if (w_accept) begin
            if (w_sel_lock) begin
                w_lk_next = w_port ? LK_OWN1 : LK_OWN0;
            end else begin
                w_lk_next = LK_FREE;
            end
        end
    end
`endif

endmodule

// File: doc/dffram_rr_arbiter.md
Name: dffram_rr_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of one single-port (1RW) DFFRAM macro: word array with byte write enables plus an optional output register.
- Two requesters (e.g. CPU fetch and DMA) share the macro through valid/ready handshakes.
- Drives a registered command (EN/WE/A/Di) to the RAM each cycle.
- Routes read data back to the originating requester after the RAM read latency, using an in-flight tag pipeline.

Parameters:
- AW, 5, RAM word-address width (5 = 32 words).
- WSIZE, 4, word size in bytes; data width is 8*WSIZE.
- RD_LAT, 1, cycles from RAM command edge to valid ram_do (1 = no output register, 2 = output register); legal range 1..2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- p0_valid  in  1  port-0 request valid.
- p0_ready  out  1  port-0 request accepted this cycle.
- p0_we  in  WSIZE  port-0 byte write enables; all-zero = read.
- p0_addr  in  AW  port-0 word address.
- p0_di  in  8*WSIZE  port-0 write data.
- p0_rvalid  out  1  port-0 read data valid (1-cycle pulse).
- p0_rdata  out  8*WSIZE  port-0 read data.
- p1_valid, p1_ready, p1_we, p1_addr, p1_di, p1_rvalid, p1_rdata: same as port 0, for port 1.
- ram_en  out  1  RAM select for this cycle.
- ram_we  out  WSIZE  RAM byte write enables.
- ram_a  out  AW  RAM word address.
- ram_di  out  8*WSIZE  RAM write data.
- ram_do  in  8*WSIZE  RAM read data.

Behaviour:
- Clock and reset: one clock, CLK; reset is asynchronous and active-high, RST.
- Reset values: ram_en=0, ram_we=0, ram_a=0, ram_di=0, p0_rvalid=p1_rvalid=0, tag pipeline cleared, last_grant=1, so port 0 wins the first contention.
- Arbitration (combinational from valids and last_grant):
  - Only p0 valid: p0_ready=1.
  - Only p1 valid: p1_ready=1.
  - Both valid: grant the port != last_grant.
  - At most one ready high per cycle.
  - ready never asserts without its own valid.
- Acceptance: valid&ready at rising edge N.
  - last_grant <= granted port.
  - At edge N, ram_en<=1, ram_we<=granted we, ram_a<=addr, ram_di<=di; these hold for cycle N..N+1.
  - No acceptance: ram_en<=0, ram_we<=0; ram_a and ram_di hold their previous values.
- Throughput: one accepted request per cycle, back-to-back, no bubbles.
- Read tagging: a read (we==0) pushes {valid=1, port} into an RD_LAT+1 deep shift register; a write pushes valid=0.
- Read response:
  - px_rvalid=1 for exactly one cycle, RD_LAT cycles after the command edge, when the tag exits with port==x.
  - px_rdata=ram_do in that cycle, otherwise 0.
  - Responses return in acceptance order.
  - No backpressure on responses: requesters must accept.
- Write completion: a write is complete once accepted; no response. A read issued the cycle after a write to the same address returns the new data, because the RAM commits the write before the next command.
- Partial writes: bytes with we=0 are left unchanged in the RAM; the arbiter passes we unmodified.
- Reset mid-operation: in-flight reads are dropped, and no rvalid is produced for them after RST deasserts. RST asserted with valid high → ready forced 0.
- Address wrap: addr is passed through as-is; no range check.

Optional Feature:
- Macro DFFRAM_ARB_LOCK_EN.
- Defined: adds inputs p0_lock, p1_lock (1 bit each).
  - When a port is accepted with lock=1, it owns the arbiter: the other port gets ready=0 even if valid.
  - Ownership ends on the first accepted beat from the owner with lock=0, or when RST is asserted.
  - While the owner is idle (valid=0), no grant is issued to either port.
  - last_grant updates normally.
- Undefined: no lock ports; pure round-robin as above.

Test Plan:
- Reset / idle: RST pulse mid-run with a read in flight (RD_LAT=2) → no p*_rvalid afterwards; ram_en=0, ram_we=0, all outputs 0 after reset.
- Single port write then read: p0 writes addr 5 data 0xDEADBEEF we=0xF at edge N, reads addr 5 at N+1 → ram_en high cycles N..N+2; p0_rvalid at N+1+RD_LAT with p0_rdata=0xDEADBEEF.
- Byte write: write 0x11223344 we=0xF, then 0xAA000000 we=0x8, read → 0xAA223344.
- Contention: both valid continuously reading addrs 1 (p0) and 2 (p1) → grants alternate p0,p1,p0,…; p0 first after reset; every rvalid matches its own address data; no overlap.
- Mixed back-to-back: p1 read, p0 write, p1 read on consecutive edges → exactly two p1_rvalid pulses, in order, none on p0.
- Lock (DFFRAM_ARB_LOCK_EN): p1 locks for 4 beats with p0 valid throughout → p0_ready=0 for those 4 beats; p0 granted on the next cycle after p1's lock=0 beat.
